// File: rtl/demux_1x2_8bit_reg_pkg.sv
// demux_1x2_8bit_reg_pkg: shared channel-state enum, select encodings and stats counter width
package demux_1x2_8bit_reg_pkg;
  typedef enum logic {CH_EMPTY = 1'b0, CH_FULL = 1'b1} ch_state_t;
  localparam logic DEMUX_SEL_A = 1'b0;
  localparam logic DEMUX_SEL_B = 1'b1;
  localparam int DEMUX_CNT_W = 16;
endpackage

// File: rtl/demux_1x2_8bit_reg_out_slot.sv
// demux_out_slot: one-entry output register + EMPTY/FULL FSM (clk, rst_n, load/din in, data/valid out, ready in, free out, cnt out under DEMUX_1X2_STATS_EN)
module demux_out_slot
  import demux_1x2_8bit_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
`ifdef DEMUX_1X2_STATS_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt
`endif
);
  ch_state_t state;
  logic drain;
  assign valid = state == CH_FULL;
  assign drain = valid && ready;
  assign free  = !valid || ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CH_EMPTY;
      data  <= '0;
    end else if (load) begin
      state <= CH_FULL;
      data  <= din;
    end else if (drain) begin
      state <= CH_EMPTY;
    end
  end
`ifdef DEMUX_1X2_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (drain) cnt <= cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/demux_1x2_8bit_reg.sv
// demux_1x2_8bit_reg: registered 1-to-2 valid/ready demux (i_clk, i_rst_n, IN/Sel/in_valid/in_ready in, OUT_A/a_valid/a_ready and OUT_B/b_valid/b_ready out, cnt_a/cnt_b under DEMUX_1X2_STATS_EN)
module demux_1x2_8bit_reg
  import demux_1x2_8bit_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] IN,
  input  logic             Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] OUT_A,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] OUT_B,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX_1X2_STATS_EN
  ,
  output logic [DEMUX_CNT_W-1:0] cnt_a,
  output logic [DEMUX_CNT_W-1:0] cnt_b
`endif
);
  logic a_free, b_free, accept;
  assign in_ready = i_rst_n && (Sel == DEMUX_SEL_B ? b_free : a_free);
  assign accept   = in_valid && in_ready;
  demux_out_slot #(.WIDTH(WIDTH)) u_a (
    .clk(i_clk), .rst_n(i_rst_n), .load(accept && Sel == DEMUX_SEL_A), .din(IN),
    .ready(a_ready), .data(OUT_A), .valid(a_valid), .free(a_free)
`ifdef DEMUX_1X2_STATS_EN
    , .cnt(cnt_a)
`endif
  );
  demux_out_slot #(.WIDTH(WIDTH)) u_b (
    .clk(i_clk), .rst_n(i_rst_n), .load(accept && Sel == DEMUX_SEL_B), .din(IN),
    .ready(b_ready), .data(OUT_B), .valid(b_valid), .free(b_free)
`ifdef DEMUX_1X2_STATS_EN
    , .cnt(cnt_b)
`endif
  );
endmodule

// File: doc/demux_1x2_8bit_reg.md
# demux_1x2_8bit_reg

Registered 1-to-2 demultiplexer for 8-bit FPU datapath fields such as exponents. It is the steering counterpart to the 2-to-1 operand select. One input stream with a valid/ready handshake is routed by a per-beat select bit to one of two output channels. Each output channel is held in its own one-entry output register, so both channels can stall independently. The block sits between the FPU exponent/normalize stage and its two consumers: the rounding path and the exception/special-case path.

## Interface
- WIDTH, 8: data width per beat.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- IN  in  WIDTH  input data beat.
- Sel  in  1  destination for this beat: 0 routes to OUT_A, 1 routes to OUT_B; qualified by in_valid.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- OUT_A  out  WIDTH  channel A data.
- a_valid  out  1  channel A holds a beat.
- a_ready  in  1  channel A consumer takes the beat.
- OUT_B  out  WIDTH  channel B data.
- b_valid  out  1  channel B holds a beat.
- b_ready  in  1  channel B consumer takes the beat.

## Operation
- Per channel, a two-state FSM: EMPTY and FULL.
  - EMPTY→FULL on an accept steered to that channel.
  - FULL→EMPTY on drain (x_valid && x_ready) with no new accept steered to it.
  - FULL→FULL on drain plus a simultaneous accept (pass-through refill).
- Accept = in_valid && in_ready.
- in_ready = target channel EMPTY, or target channel FULL and draining this cycle. The target is selected by the current Sel.
- in_ready depends combinationally on Sel, a_ready and b_ready. No combinational path exists from IN to any output.
- On accept, IN is written into the target channel's data register and that channel goes FULL. The non-target channel is unaffected.
- OUT_x and x_valid are driven only from registers. OUT_x is stable while x_valid=1 and x_ready=0.
- Order is preserved within each channel. No ordering guarantee exists across channels.
- When in_valid=0, Sel is ignored.
- A blocked channel does not block beats steered to the other channel.
- No beat is ever dropped or duplicated.

## Timing
- Reset (i_rst_n=0 at a rising edge): both channels EMPTY; a_valid=0, b_valid=0, OUT_A=0, OUT_B=0.
- in_ready during reset is 0. After reset deasserts, in_ready is 1 for either Sel value.
- Reset mid-transfer discards any held beats. A beat presented in the reset cycle is not accepted.
- Latency: a beat accepted at edge N appears on x_valid/OUT_x right after edge N, visible in cycle N+1.
- Throughput: one beat per cycle per channel while its consumer keeps x_ready=1.
- Simultaneous events:
  - Drain of A with an accept to B: both occur.
  - Drain of A with an accept to A: refill, a_valid stays 1 and OUT_A takes the new value.
- Full case: target FULL and x_ready=0 → in_ready=0, and the input must hold IN and Sel stable until accepted.

## Configuration
- DEMUX_1X2_STATS_EN defined: adds outputs cnt_a and cnt_b, each 16 bits.
  - Each counts beats delivered (drain handshakes) on its channel.
  - Reset to 0; wrap from 0xFFFF to 0x0000 without saturation.
- Undefined: the counters and their ports are absent. Datapath behaviour is identical in both builds.

## Structure
- Shared FPU package contains:
  - typedef for the per-channel state enum (CH_EMPTY, CH_FULL).
  - constant DEMUX_SEL_A=1'b0 and DEMUX_SEL_B=1'b1.
  - constant DEMUX_CNT_W=16.
- One sub-module: demux_out_slot, the per-channel one-entry register plus FSM, instantiated twice.
- The top level holds only the steering and in_ready logic.

## Test plan
- Reset, then IN=0x7F, Sel=0, in_valid=1, a_ready=1 → next cycle a_valid=1 and OUT_A=0x7F, with b_valid=0 throughout.
- a_ready=0, send 0x10 to A, then hold 0x11 to A → in_ready=0 and OUT_A stays 0x10. Raise a_ready → 0x10 drains and 0x11 loads in the same edge.
- Channel A stalled holding 0x20, send 0x30 with Sel=1 → accepted, and OUT_B=0x30 next cycle. A's data is unchanged.
- Back-to-back 0x01..0x08 with alternating Sel and both readies at 1 → A receives 0x01,0x03,0x05,0x07 and B receives 0x02,0x04,0x06,0x08, one per cycle with no bubbles.
- Both channels FULL, then assert i_rst_n=0 for one edge → a_valid=b_valid=0 and OUT_A=OUT_B=0, and no stale beat appears afterward.
- With DEMUX_1X2_STATS_EN defined, deliver 65537 beats to B → cnt_b=1 and cnt_a=0.
